beta_mem_arbiter: RTL and testbench
===================================

# beta_mem_arbiter

Shared-memory front end for the BETA processor. It replaces the separate instruction and data distributed RAMs with one single-port synchronous RAM of configurable depth and read latency. It arbitrates the core's instruction-fetch port and data port onto that RAM, stalls the core through ready pulses, and flags out-of-range accesses. It sits between BETA_CORE and the memory macro inside the processor top level.

## Interface
Parameters:
- DEPTH, 2048: RAM size in 32-bit words, ≥2. AW = clog2(DEPTH).
- MEM_LAT, 1: RAM read latency in cycles, 1..4.
- FAIR, 0: contention policy. 0 = data always wins; 1 = alternate grants.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- IREQ  in  1  instruction fetch request; level, held until IRDY.
- IA  in  32  fetch byte address.
- IRDY  out  1  one-cycle fetch-complete pulse.
- ID  out  32  fetched word; valid with IRDY and held until the next fetch completes.
- MOE  in  1  data read request; level.
- MWR  in  1  data write request; level. MOE and MWR are never both high.
- MA  in  32  data byte address.
- MWD  in  32  write data.
- DRDY  out  1  one-cycle data-complete pulse.
- MRD  out  32  read word; valid with DRDY and held until the next data read completes.
- ERR  out  1  pulses with IRDY/DRDY when the access was out of range.
- MEM_EN  out  1  RAM enable.
- MEM_WE  out  1  RAM write enable.
- MEM_ADDR  out  AW  RAM word address.
- MEM_WD  out  32  RAM write data.
- MEM_RD  in  32  RAM read data; valid MEM_LAT cycles after the enable cycle.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Samples IREQ and DREQ, where DREQ = MOE|MWR.
  - With no request, the FSM stays in IDLE.
  - With a request, the FSM registers the grant, address, write data and direction, then moves to ISSUE.
- Contention (IREQ and DREQ both high):
  - FAIR=0: data is granted.
  - FAIR=1: the port not granted last is granted. The last-grant flag resets to "instruction", so the first contention goes to data.
- Range check: an access is out of range when addr[31:2] ≥ DEPTH. addr[1:0] is ignored.
- ISSUE, in-range access:
  - MEM_EN=1, MEM_ADDR=addr[AW+1:2].
  - For a write, MEM_WE=1 and MEM_WD=MWD.
  - Next state: write → DONE; read → WAIT.
- ISSUE, out-of-range access: MEM_EN=MEM_WE=0 and the FSM goes directly to DONE. Read data is forced to 0 and the write is discarded.
- WAIT: a counter runs MEM_LAT cycles. On the last one, MEM_RD is captured into ID or MRD (per grant) and the FSM goes to DONE.
- DONE:
  - The granted port's RDY is asserted. ERR is asserted if the access was out of range.
  - The FSM returns to IDLE without sampling requests.
- Requesters drop their request on the edge that ends the RDY cycle. A request still high in the following IDLE cycle starts a new access.
- A request on the losing port is not lost. It stays pending and is serviced on the next IDLE.
- Reset values: all outputs 0, ID=MRD=0, state IDLE, counter 0, last-grant = instruction.
- RESET mid-transaction: the transaction is abandoned, MEM_EN/MEM_WE drop immediately (asynchronously), and no RDY is issued.

## Timing
- Request high in IDLE cycle 0 → ISSUE in cycle 1.
- Read: capture at end of cycle 1+MEM_LAT; RDY in cycle 2+MEM_LAT. Request-to-RDY latency = MEM_LAT+2.
- Write or out-of-range access: RDY in cycle 2. Latency = 2.
- Back-to-back accesses from one port: a new access every MEM_LAT+3 cycles for reads, every 3 cycles for writes.
- RAM outputs, RDY and ERR are registered, so no combinational path runs from core inputs to any output.

## Structure
- Shared package beta_mem_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT/DONE)
  - the grant enum (GNT_I/GNT_D)
  - the localparam MAX_MEM_LAT=4
- One sub-module, beta_mem_arb_sel: a combinational grant selector taking IREQ, DREQ, FAIR and the last-grant flag.
- The latency counter is 2 bits wide.
- The module is instantiated in place of the two MAIN_DIST_MEM instances. BETA_CORE holds its pipeline on the absence of IRDY/DRDY.

## Test plan
- MEM_LAT=1: reset, then RAM preloaded word 5 = 0xDEADBEEF; IREQ with IA=0x14 → MEM_EN in cycle 1 with MEM_ADDR=5; IRDY in cycle 3 with ID=0xDEADBEEF, ERR=0.
- Write MA=0x20, MWD=0x12345678 → MEM_WE=1 with MEM_ADDR=8 in cycle 1, DRDY in cycle 2. Then MOE at the same address → MRD=0x12345678.
- IREQ and MOE raised together, FAIR=0 → DRDY first, then IRDY. With FAIR=1, three consecutive contentions → grants D, I, D.
- DEPTH=2048: MOE with MA=0x2000 → no MEM_EN; DRDY and ERR together in cycle 2; MRD=0. MWR to the same address → RAM contents unchanged.
- MEM_LAT=3 read → RDY exactly 5 cycles after the request. RESET asserted during WAIT → all outputs 0 immediately, and no RDY afterwards.

Source files
------------

// File: rtl/beta_mem_pkg.sv
// Shared types and constants for the BETA shared-memory arbiter.
package beta_mem_pkg;

  localparam int unsigned MAX_MEM_LAT = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  typedef enum logic {GNT_I, GNT_D} gnt_e;

endpackage

// File: rtl/beta_mem_arb_sel.sv
// Combinational grant selector for the fetch and data ports.
module beta_mem_arb_sel (
  input  logic ireq,
  input  logic dreq,
  input  logic fair,
  input  logic last_gnt_d,  // 1 when the previous grant went to the data port
  output logic req,
  output logic gnt_d        // 1 grants the data port, 0 the fetch port
);

  // Data wins contention unless fair mode hands it to the port not served last
  always_comb begin
    req   = ireq | dreq;
    gnt_d = 1'b0;
    if (ireq && dreq) begin
      gnt_d = !(fair && last_gnt_d);
    end else if (dreq) begin
      gnt_d = 1'b1;
    end
  end

endmodule

// File: rtl/beta_mem_arbiter.sv
// Shared single-port RAM front end: arbitrates BETA fetch and data ports onto
// one synchronous RAM, pulses ready on completion and flags out-of-range access.
module beta_mem_arbiter
  import beta_mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 2048,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned FAIR    = 0,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          IREQ,
  input  logic [31:0]   IA,
  output logic          IRDY,
  output logic [31:0]   ID,
  input  logic          MOE,
  input  logic          MWR,
  input  logic [31:0]   MA,
  input  logic [31:0]   MWD,
  output logic          DRDY,
  output logic [31:0]   MRD,
  output logic          ERR,
  output logic          MEM_EN,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_ADDR,
  output logic [31:0]   MEM_WD,
  input  logic [31:0]   MEM_RD
);

  state_e        state_q, state_d;
  gnt_e          gnt_q, gnt_d, last_gnt_q, last_gnt_d, sel_gnt;
  logic          we_q, we_d, oor_q, oor_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wd_q, wd_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   id_q, id_d, mrd_q, mrd_d;
  logic          irdy_q, irdy_d, drdy_q, drdy_d, err_q, err_d;
  logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;

  logic          dreq, sel_req, sel_gnt_d, req_oor;
  logic [31:0]   req_addr;
  logic          unused_addr_lsb;

  assign dreq    = MOE | MWR;
  assign sel_gnt = sel_gnt_d ? GNT_D : GNT_I;

  beta_mem_arb_sel u_arb_sel (
    .ireq       (IREQ),
    .dreq       (dreq),
    .fair       (FAIR != 0),
    .last_gnt_d (last_gnt_q == GNT_D),
    .req        (sel_req),
    .gnt_d      (sel_gnt_d)
  );

  assign req_addr = (sel_gnt == GNT_D) ? MA : IA;
  // Byte offset is ignored; the word index alone decides range
  assign req_oor  = (32'(req_addr[31:2]) >= DEPTH);
  assign unused_addr_lsb = ^{IA[1:0], MA[1:0]};

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    we_d       = we_q;
    oor_d      = oor_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    mrd_d      = mrd_q;
    irdy_d     = 1'b0;
    drdy_d     = 1'b0;
    err_d      = 1'b0;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_req) begin
          gnt_d      = sel_gnt;
          last_gnt_d = sel_gnt;
          addr_d     = req_addr[AW+1:2];
          oor_d      = req_oor;
          we_d       = (sel_gnt == GNT_D) && MWR;
          wd_d       = MWD;
          // RAM strobes are registered so they are live during ISSUE
          mem_en_d   = !req_oor;
          mem_we_d   = !req_oor && (sel_gnt == GNT_D) && MWR;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (oor_q || we_q) begin
          state_d = DONE;
          irdy_d  = (gnt_q == GNT_I);
          drdy_d  = (gnt_q == GNT_D);
          err_d   = oor_q;
          if (oor_q && !we_q) begin
            if (gnt_q == GNT_I) id_d = '0;
            else                mrd_d = '0;
          end
        end else begin
          cnt_d   = 2'(MEM_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          if (gnt_q == GNT_I) id_d = MEM_RD;
          else                mrd_d = MEM_RD;
          irdy_d  = (gnt_q == GNT_I);
          drdy_d  = (gnt_q == GNT_D);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset abandons any transaction
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      gnt_q      <= GNT_I;
      last_gnt_q <= GNT_I;
      we_q       <= 1'b0;
      oor_q      <= 1'b0;
      addr_q     <= '0;
      wd_q       <= '0;
      cnt_q      <= '0;
      id_q       <= '0;
      mrd_q      <= '0;
      irdy_q     <= 1'b0;
      drdy_q     <= 1'b0;
      err_q      <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      we_q       <= we_d;
      oor_q      <= oor_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      mrd_q      <= mrd_d;
      irdy_q     <= irdy_d;
      drdy_q     <= drdy_d;
      err_q      <= err_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
    end
  end

  assign IRDY     = irdy_q;
  assign DRDY     = drdy_q;
  assign ERR      = err_q;
  assign ID       = id_q;
  assign MRD      = mrd_q;
  assign MEM_EN   = mem_en_q;
  assign MEM_WE   = mem_we_q;
  assign MEM_ADDR = addr_q;
  assign MEM_WD   = wd_q;

endmodule

// File: tb/tb_beta_mem_arbiter.sv
// Bench for beta_mem_arbiter: instance 0 (MEM_LAT=1, FAIR=0), instance 1 (MEM_LAT=3, FAIR=1),
// each with a behavioural synchronous RAM.
module tb_beta_mem_arbiter;

  localparam int unsigned LATS  [2] = '{1, 3};
  localparam int unsigned FAIRS [2] = '{0, 1};

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [2];
  logic        ireq   [2];
  logic [31:0] ia     [2];
  logic        irdy   [2];
  logic [31:0] id     [2];
  logic        moe    [2];
  logic        mwr    [2];
  logic [31:0] ma     [2];
  logic [31:0] mwd    [2];
  logic        drdy   [2];
  logic [31:0] mrd    [2];
  logic        err    [2];
  logic        mem_en [2];
  logic        mem_we [2];
  logic [10:0] mem_addr [2];
  logic [31:0] mem_wd [2];
  logic [31:0] mem_rd [2];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] mem  [2048];
    logic [31:0] pipe [4];

    beta_mem_arbiter #(
      .DEPTH   (2048),
      .MEM_LAT (LATS[g]),
      .FAIR    (FAIRS[g])
    ) u_dut (
      .CLK      (clk),
      .RESET    (rst[g]),
      .IREQ     (ireq[g]),
      .IA       (ia[g]),
      .IRDY     (irdy[g]),
      .ID       (id[g]),
      .MOE      (moe[g]),
      .MWR      (mwr[g]),
      .MA       (ma[g]),
      .MWD      (mwd[g]),
      .DRDY     (drdy[g]),
      .MRD      (mrd[g]),
      .ERR      (err[g]),
      .MEM_EN   (mem_en[g]),
      .MEM_WE   (mem_we[g]),
      .MEM_ADDR (mem_addr[g]),
      .MEM_WD   (mem_wd[g]),
      .MEM_RD   (mem_rd[g])
    );

    // RAM model: preload while in reset, read data appears LATS[g] cycles after enable
    always @(posedge clk) begin
      if (rst[g]) begin
        mem[0]    <= 32'h1111_0000;
        mem[5]    <= 32'hDEAD_BEEF;
        mem[2047] <= 32'hA5A5_0001;
      end else if (mem_en[g] && mem_we[g]) begin
        mem[mem_addr[g]] <= mem_wd[g];
      end
      pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g]] : 32'hBAD0_BAD0;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
      pipe[3] <= pipe[2];
    end
    assign mem_rd[g] = pipe[LATS[g]-1];
  end

  typedef struct {
    bit          is_d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    bit          en;
    logic [10:0] maddr;
    logic [31:0] rdata;
    bit          err;
    string       name;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drives one access on instance inst and checks strobes, latency, data and error
  task automatic access(input int inst, input vec_t v);
    int n;
    bit done;
    if (v.is_d) begin
      ma[inst]  = v.addr;
      mwd[inst] = v.wdata;
      if (v.wr) mwr[inst] = 1'b1;
      else      moe[inst] = 1'b1;
    end else begin
      ia[inst]   = v.addr;
      ireq[inst] = 1'b1;
    end
    n = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      if (n == 1) begin
        check({v.name, " mem_en"}, 32'(mem_en[inst]), 32'(v.en));
        check({v.name, " mem_we"}, 32'(mem_we[inst]), 32'(v.en && v.wr));
        if (v.en) check({v.name, " mem_addr"}, 32'(mem_addr[inst]), 32'(v.maddr));
        if (v.en && v.wr) check({v.name, " mem_wd"}, mem_wd[inst], v.wdata);
      end
      if (v.is_d ? drdy[inst] : irdy[inst]) begin
        done = 1'b1;
        check({v.name, " latency"}, n, v.lat);
        check({v.name, " err"}, 32'(err[inst]), 32'(v.err));
        if (!v.wr) check({v.name, " rdata"}, v.is_d ? mrd[inst] : id[inst], v.rdata);
      end
      @(posedge clk);
      #1;
      if (done) begin
        ireq[inst] = 1'b0;
        moe[inst]  = 1'b0;
        mwr[inst]  = 1'b0;
      end
      n++;
    end
    if (!done) begin
      check({v.name, " rdy_timeout"}, 32'd0, 32'd1);
      ireq[inst] = 1'b0;
      moe[inst]  = 1'b0;
      mwr[inst]  = 1'b0;
    end
  endtask

  // Starts a read on instance 1, resets it in cycle cyc and expects silence afterwards
  task automatic reset_mid(input int cyc, input string nm);
    int seen;
    ma[1]  = 32'h14;
    moe[1] = 1'b1;
    for (int n = 0; n < cyc; n++) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    if (cyc == 1) check({nm, " pre_mem_en"}, 32'(mem_en[1]), 32'd1);
    #1;
    rst[1] = 1'b1;
    moe[1] = 1'b0;
    #1;
    check({nm, " outs_zero"}, 32'({irdy[1], drdy[1], err[1], mem_en[1], mem_we[1]}), 32'd0);
    check({nm, " id_zero"}, id[1], 32'd0);
    check({nm, " mrd_zero"}, mrd[1], 32'd0);
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (irdy[1] || drdy[1]) seen++;
      @(posedge clk);
      #1;
    end
    check({nm, " no_rdy_after"}, seen, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d_cyc, i_cyc, ng;
    logic [31:0] d_data, i_data;
    bit gnt_seq [3];
    int gnt_cyc [3];

    //          is_d wr  addr            wdata          lat en maddr  rdata          err name
    vecs[0]  = '{1'b0, 1'b0, 32'h0000_0014, 32'h0,         3, 1'b1, 11'd5,    32'hDEAD_BEEF, 1'b0, "ifetch_w5"};
    vecs[1]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 2, 1'b1, 11'd8,    32'h0,         1'b0, "dwrite_w8"};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         3, 1'b1, 11'd8,    32'h1234_5678, 1'b0, "dread_w8"};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,         2, 1'b0, 11'd0,    32'h0,         1'b1, "dread_oor"};
    vecs[4]  = '{1'b1, 1'b1, 32'h0000_2000, 32'hCAFE_F00D, 2, 1'b0, 11'd0,    32'h0,         1'b1, "dwrite_oor"};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         3, 1'b1, 11'd0,    32'h1111_0000, 1'b0, "dread_w0_intact"};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0023, 32'h0,         3, 1'b1, 11'd8,    32'h1234_5678, 1'b0, "dread_lowbits"};
    vecs[7]  = '{1'b0, 1'b0, 32'h0000_1FFC, 32'h0,         3, 1'b1, 11'd2047, 32'hA5A5_0001, 1'b0, "ifetch_last"};
    vecs[8]  = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         2, 1'b0, 11'd0,    32'h0,         1'b1, "ifetch_oor"};
    vecs[9]  = '{1'b1, 1'b1, 32'h0000_1FFC, 32'h0BAD_F00D, 2, 1'b1, 11'd2047, 32'h0,         1'b0, "dwrite_last"};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_1FFC, 32'h0,         3, 1'b1, 11'd2047, 32'h0BAD_F00D, 1'b0, "dread_last"};

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; ireq[i] = 1'b0; moe[i] = 1'b0; mwr[i] = 1'b0;
      ia[i] = '0; ma[i] = '0; mwd[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_outs", 32'({irdy[i], drdy[i], err[i], mem_en[i], mem_we[i]}), 32'd0);
      check("reset_id_mrd", id[i] | mrd[i], 32'd0);
    end
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) access(0, vecs[i]);

    // FAIR=0 contention: data first (cycle 3), fetch re-arbitrated next IDLE (cycle 7)
    ia[0] = 32'h14; ireq[0] = 1'b1;
    ma[0] = 32'h20; moe[0]  = 1'b1;
    d_cyc = -1; i_cyc = -1; d_data = '0; i_data = '0;
    n = 0;
    while (i_cyc < 0 && n < 30) begin
      @(negedge clk);
      if (drdy[0]) begin d_cyc = n; d_data = mrd[0]; end
      if (irdy[0]) begin i_cyc = n; i_data = id[0]; end
      @(posedge clk);
      #1;
      if (d_cyc == n) moe[0] = 1'b0;
      if (i_cyc == n) ireq[0] = 1'b0;
      n++;
    end
    ireq[0] = 1'b0; moe[0] = 1'b0;
    check("fair0 drdy_cycle", d_cyc, 32'd3);
    check("fair0 irdy_cycle", i_cyc, 32'd7);
    check("fair0 mrd", d_data, 32'h1234_5678);
    check("fair0 id", i_data, 32'hDEAD_BEEF);

    // MEM_LAT=3 read latency on instance 1
    access(1, '{1'b0, 1'b0, 32'h14, 32'h0, 5, 1'b1, 11'd5, 32'hDEAD_BEEF, 1'b0, "lat3_ifetch"});

    // FAIR=1 with both ports held high: grants D, I, D, 6 cycles apart
    ia[1] = 32'h14; ma[1] = 32'h14; ireq[1] = 1'b1; moe[1] = 1'b1;
    ng = 0; n = 0;
    while (ng < 3 && n < 60) begin
      @(negedge clk);
      if (drdy[1] || irdy[1]) begin
        gnt_seq[ng] = drdy[1];
        gnt_cyc[ng] = n;
        ng++;
      end
      @(posedge clk);
      #1;
      n++;
    end
    ireq[1] = 1'b0; moe[1] = 1'b0;
    check("fair1 grant_count", ng, 32'd3);
    if (ng == 3) begin
      check("fair1 grant0_is_d", 32'(gnt_seq[0]), 32'd1);
      check("fair1 grant1_is_d", 32'(gnt_seq[1]), 32'd0);
      check("fair1 grant2_is_d", 32'(gnt_seq[2]), 32'd1);
      check("fair1 grant0_cycle", gnt_cyc[0], 32'd5);
      check("fair1 grant1_cycle", gnt_cyc[1], 32'd11);
      check("fair1 grant2_cycle", gnt_cyc[2], 32'd17);
    end
    @(negedge clk);
    check("fair1 id_held", id[1], 32'hDEAD_BEEF);
    @(posedge clk);
    #1;

    reset_mid(2, "rst_wait");
    reset_mid(1, "rst_issue");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
